// File: rtl/sarray_drain.sv
// Output-side reader for the systolic array: captures whole result columns into
// a ping-pong buffer and streams them out one word per handshake beat.
module sarray_drain #(
    parameter  int W   = 8,
    parameter  int DIM = 32,
    localparam int IW  = $clog2(DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             col_valid,
    input  logic [DIM*W-1:0] col_data,
    output logic             col_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_row,
    output logic [IW-1:0]    out_col,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                          state_q;
    logic [1:0][DIM-1:0][W-1:0]      bank_q;
    logic [1:0]                      full_q;
    logic                            wr_bank_q;
    logic                            rd_bank_q;
    logic [IW-1:0]                   row_q;
    logic [IW-1:0]                   col_q;
    logic [IW:0]                     acc_q;
    logic                            done_q;

    logic cap, beat, col_end, frame_end;

    // A bank freed this cycle only shows up in full_q next cycle, so no same-cycle reuse.
    assign col_ready = (state_q == RUN) && !full_q[wr_bank_q] && (acc_q < (IW+1)'(DIM));
    assign cap       = col_valid && col_ready;
    assign out_valid = full_q[rd_bank_q];
    assign beat      = out_valid && out_ready;
    assign col_end   = beat && (row_q == IW'(DIM-1));
    assign frame_end = col_end && (col_q == IW'(DIM-1));

    // Gated so stale bank contents never leak out while nothing is valid.
    assign out_data   = out_valid ? bank_q[rd_bank_q][row_q] : '0;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign busy       = (state_q == RUN);
    assign frame_done = done_q;

    always_ff @(posedge clk) begin
        if (cap) bank_q[wr_bank_q] <= col_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        full_q    <= '0;
                        wr_bank_q <= 1'b0;
                        rd_bank_q <= 1'b0;
                        row_q     <= '0;
                        col_q     <= '0;
                        acc_q     <= '0;
                    end
                end
                RUN: begin
                    // cap and col_end never target the same bank: col_ready needs wr bank empty.
                    if (cap) begin
                        full_q[wr_bank_q] <= 1'b1;
                        wr_bank_q         <= ~wr_bank_q;
                        acc_q             <= acc_q + (IW+1)'(1);
                    end
                    if (beat) begin
                        if (col_end) begin
                            row_q             <= '0;
                            full_q[rd_bank_q] <= 1'b0;
                            rd_bank_q         <= ~rd_bank_q;
                            if (frame_end) begin
                                col_q   <= '0;
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                col_q <= col_q + IW'(1);
                            end
                        end else begin
                            row_q <= row_q + IW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
